// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory port arbiter.
// Master 0 is instruction fetch, master 1 is load/store.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_TOUT = 2'd3
  } state_t;

  localparam int M_IFU = 0;
  localparam int M_LSU = 1;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IFU  = 2'b01;
  localparam logic [1:0] GNT_LSU  = 2'b10;

  // A zero timeout still needs a legal, non-zero-width timer.
  function automatic int tmr_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner select for the two memory masters, one-hot result.
// Round-robin hands a tie to the master that did not win last time.
module arb_rr_pick
  import mem_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] req_i,
  input  logic [1:0] last_grant_i,
  output logic [1:0] pick_o
);

  always_comb begin
    // NOTE: default first so every path assigns pick_o and no latch is inferred.
    pick_o = GNT_NONE;
    if (FIXED_PRIO) begin
      if (req_i[M_LSU]) begin
        pick_o = GNT_LSU;
      end else if (req_i[M_IFU]) begin
        pick_o = GNT_IFU;
      end
    end else begin
      case (req_i)
        2'b01:   pick_o = GNT_IFU;
        2'b10:   pick_o = GNT_LSU;
        2'b11:   pick_o = (last_grant_i == GNT_LSU) ? GNT_IFU : GNT_LSU;
        default: pick_o = GNT_NONE;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises IFU and LSU accesses onto one memory slave port, one transaction
// outstanding at a time, with a response timeout that returns an error.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 255,
  parameter int FIXED_PRIO = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              m_req_valid,
  output logic [1:0]              m_req_ready,
  input  logic [2*ADDR_W-1:0]     m_req_addr,
  input  logic [1:0]              m_req_write,
  input  logic [2*DATA_W-1:0]     m_req_wdata,
  input  logic [2*(DATA_W/8)-1:0] m_req_wstrb,
  output logic [1:0]              m_resp_valid,
  input  logic [1:0]              m_resp_ready,
  output logic [DATA_W-1:0]       m_resp_rdata,
  output logic                    m_resp_err,
  output logic                    s_req_valid,
  input  logic                    s_req_ready,
  output logic [ADDR_W-1:0]       s_req_addr,
  output logic                    s_req_write,
  output logic [DATA_W-1:0]       s_req_wdata,
  output logic [DATA_W/8-1:0]     s_req_wstrb,
  input  logic                    s_resp_valid,
  output logic                    s_resp_ready,
  input  logic [DATA_W-1:0]       s_resp_rdata,
  input  logic                    s_resp_err,
  output logic [1:0]              grant,
  output logic                    busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int TMR_W  = tmr_width(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_MAX   = '1;
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);

  state_t             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic [1:0]         last_grant_q, last_grant_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [TMR_W-1:0]   timer_inc;
  logic [1:0]         pick;
  logic               gnt_lsu;
  logic               owner_resp_ready;

  arb_rr_pick #(
    .FIXED_PRIO (FIXED_PRIO != 0)
  ) u_pick (
    .req_i        (m_req_valid),
    .last_grant_i (last_grant_q),
    .pick_o       (pick)
  );

  // Request fields follow the owner; in IDLE the mux output is ignored.
  assign gnt_lsu     = grant_q[M_LSU];
  assign s_req_addr  = gnt_lsu ? m_req_addr[ADDR_W +: ADDR_W]  : m_req_addr[0 +: ADDR_W];
  assign s_req_wdata = gnt_lsu ? m_req_wdata[DATA_W +: DATA_W] : m_req_wdata[0 +: DATA_W];
  assign s_req_wstrb = gnt_lsu ? m_req_wstrb[STRB_W +: STRB_W] : m_req_wstrb[0 +: STRB_W];
  assign s_req_write = m_req_write[gnt_lsu];

  assign owner_resp_ready = |(grant_q & m_resp_ready);
  assign timer_inc        = (timer_q == TMR_MAX) ? timer_q : timer_q + 1'b1;

  assign grant = grant_q;
  assign busy  = (state_q != ST_IDLE);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    m_req_ready  = 2'b00;
    m_resp_valid = 2'b00;
    m_resp_rdata = s_resp_rdata;
    m_resp_err   = s_resp_err;
    s_req_valid  = 1'b0;
    s_resp_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Sink for stray or late slave responses (e.g. after a timeout).
        s_resp_ready = 1'b1;
        if (|m_req_valid) begin
          grant_d = pick;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        s_req_valid = 1'b1;
        m_req_ready = grant_q & {2{s_req_ready}};
        if (s_req_ready) begin
          timer_d = '0;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        m_resp_valid = grant_q & {2{s_resp_valid}};
        s_resp_ready = owner_resp_ready;
        if (s_resp_valid) begin
          if (owner_resp_ready) begin
            last_grant_d = grant_q;
            grant_d      = GNT_NONE;
            state_d      = ST_IDLE;
          end
        end else begin
          // A response arriving this cycle keeps the timer from advancing,
          // so it always beats the timeout.
          timer_d = timer_inc;
          if ((TIMEOUT != 0) && (timer_inc == TMR_LIMIT)) begin
            state_d = ST_TOUT;
          end
        end
      end

      ST_TOUT: begin
        m_resp_valid = grant_q;
        m_resp_rdata = '0;
        m_resp_err   = 1'b1;
        if (owner_resp_ready) begin
          last_grant_d = grant_q;
          grant_d      = GNT_NONE;
          state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= GNT_NONE;
      last_grant_q <= GNT_LSU;
      timer_q      <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values together.
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin and a fixed-priority instance
// share one master/slave model, selected by sel_fp.
module tb_mem_arbiter;

  typedef struct {
    int          m;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          cyc;
  } sreq_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sel_fp;

  logic [1:0]  m_req_valid;
  logic [63:0] m_req_addr;
  logic [1:0]  m_req_write;
  logic [63:0] m_req_wdata;
  logic [7:0]  m_req_wstrb;
  logic [1:0]  m_resp_ready;
  logic        s_req_ready;
  logic        s_resp_valid;
  logic [31:0] s_resp_rdata;
  logic        s_resp_err;

  logic [1:0]  m_req_ready_r,  m_req_ready_f,  m_req_ready;
  logic [1:0]  m_resp_valid_r, m_resp_valid_f, m_resp_valid;
  logic [31:0] m_resp_rdata_r, m_resp_rdata_f, m_resp_rdata;
  logic        m_resp_err_r,   m_resp_err_f,   m_resp_err;
  logic        s_req_valid_r,  s_req_valid_f,  s_req_valid;
  logic [31:0] s_req_addr_r,   s_req_addr_f,   s_req_addr;
  logic        s_req_write_r,  s_req_write_f,  s_req_write;
  logic [31:0] s_req_wdata_r,  s_req_wdata_f,  s_req_wdata;
  logic [3:0]  s_req_wstrb_r,  s_req_wstrb_f,  s_req_wstrb;
  logic        s_resp_ready_r, s_resp_ready_f, s_resp_ready;
  logic [1:0]  grant_r,        grant_f,        grant;
  logic        busy_r,         busy_f,         busy;

  logic [1:0] mrv_r, mrv_f;
  logic       srr_r, srr_f, srv_r, srv_f;

  assign mrv_r = sel_fp ? 2'b00 : m_req_valid;
  assign mrv_f = sel_fp ? m_req_valid : 2'b00;
  assign srr_r = !sel_fp && s_req_ready;
  assign srr_f = sel_fp && s_req_ready;
  assign srv_r = !sel_fp && s_resp_valid;
  assign srv_f = sel_fp && s_resp_valid;

  assign m_req_ready  = sel_fp ? m_req_ready_f  : m_req_ready_r;
  assign m_resp_valid = sel_fp ? m_resp_valid_f : m_resp_valid_r;
  assign m_resp_rdata = sel_fp ? m_resp_rdata_f : m_resp_rdata_r;
  assign m_resp_err   = sel_fp ? m_resp_err_f   : m_resp_err_r;
  assign s_req_valid  = sel_fp ? s_req_valid_f  : s_req_valid_r;
  assign s_req_addr   = sel_fp ? s_req_addr_f   : s_req_addr_r;
  assign s_req_write  = sel_fp ? s_req_write_f  : s_req_write_r;
  assign s_req_wdata  = sel_fp ? s_req_wdata_f  : s_req_wdata_r;
  assign s_req_wstrb  = sel_fp ? s_req_wstrb_f  : s_req_wstrb_r;
  assign s_resp_ready = sel_fp ? s_resp_ready_f : s_resp_ready_r;
  assign grant        = sel_fp ? grant_f        : grant_r;
  assign busy         = sel_fp ? busy_f         : busy_r;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .m_req_valid(mrv_r), .m_req_ready(m_req_ready_r), .m_req_addr(m_req_addr),
    .m_req_write(m_req_write), .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
    .m_resp_valid(m_resp_valid_r), .m_resp_ready(m_resp_ready),
    .m_resp_rdata(m_resp_rdata_r), .m_resp_err(m_resp_err_r),
    .s_req_valid(s_req_valid_r), .s_req_ready(srr_r), .s_req_addr(s_req_addr_r),
    .s_req_write(s_req_write_r), .s_req_wdata(s_req_wdata_r), .s_req_wstrb(s_req_wstrb_r),
    .s_resp_valid(srv_r), .s_resp_ready(s_resp_ready_r),
    .s_resp_rdata(s_resp_rdata), .s_resp_err(s_resp_err),
    .grant(grant_r), .busy(busy_r)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .m_req_valid(mrv_f), .m_req_ready(m_req_ready_f), .m_req_addr(m_req_addr),
    .m_req_write(m_req_write), .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
    .m_resp_valid(m_resp_valid_f), .m_resp_ready(m_resp_ready),
    .m_resp_rdata(m_resp_rdata_f), .m_resp_err(m_resp_err_f),
    .s_req_valid(s_req_valid_f), .s_req_ready(srr_f), .s_req_addr(s_req_addr_f),
    .s_req_write(s_req_write_f), .s_req_wdata(s_req_wdata_f), .s_req_wstrb(s_req_wstrb_f),
    .s_resp_valid(srv_f), .s_resp_ready(s_resp_ready_f),
    .s_resp_rdata(s_resp_rdata), .s_resp_err(s_resp_err),
    .grant(grant_f), .busy(busy_f)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int          pend [2];
  int          cyc;
  int          sl_req_lat, sl_resp_lat, sl_phase, sl_cnt, sl_resp_hs_cnt;
  bit          sl_no_resp;
  logic [31:0] sl_rdata;
  logic [1:0]  exp_grant_chk;
  resp_t       resp_q[$];
  sreq_t       sreq_q[$];
  int          acc_q[$];
  int          exp_rr[4] = '{0, 1, 0, 1};
  int          exp_fp[5] = '{1, 1, 1, 1, 0};

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Master and slave model: samples at negedge, drives just after posedge.
  initial begin : bfm
    logic       req_hs, resp_hs;
    logic [1:0] mreq_hs;
    forever begin
      @(negedge clk);
      req_hs  = s_req_valid && s_req_ready;
      resp_hs = s_resp_valid && s_resp_ready;
      mreq_hs = m_req_valid & m_req_ready;
      check("nongrant_quiet", {m_req_ready & ~grant, m_resp_valid & ~grant}, 4'h0);
      check("busy_grant", {busy, ($countones(grant) <= 1)}, {(grant != 2'b00), 1'b1});
      if (busy && exp_grant_chk != 2'b00) check("grant_hold", grant, exp_grant_chk);
      for (int i = 0; i < 2; i++) begin
        if (m_resp_valid[i] && m_resp_ready[i])
          resp_q.push_back('{i, m_resp_rdata, m_resp_err, cyc});
        if (mreq_hs[i]) acc_q.push_back(i);
      end
      if (req_hs)
        sreq_q.push_back('{s_req_addr, s_req_write, s_req_wdata, s_req_wstrb, cyc + 1});
      @(posedge clk);
      cyc++;
      #1;
      if (!rst) begin
        pend[0] = 0; pend[1] = 0;
        m_req_valid = 2'b00; s_req_ready = 1'b0; s_resp_valid = 1'b0;
        sl_phase = 0; sl_cnt = 0;
        continue;
      end
      for (int i = 0; i < 2; i++) begin
        if (mreq_hs[i] && pend[i] > 0) pend[i]--;
        m_req_valid[i] = (pend[i] > 0);
      end
      if (sl_phase == 0) begin
        if (req_hs) begin
          s_req_ready = 1'b0; sl_phase = 1; sl_cnt = 0;
        end else if (s_req_valid) begin
          sl_cnt++;
          s_req_ready = (sl_cnt >= sl_req_lat);
        end
      end else begin
        if (resp_hs) begin
          s_resp_valid = 1'b0; sl_phase = 0; sl_cnt = 0; sl_resp_hs_cnt++;
        end else if (!sl_no_resp) begin
          sl_cnt++;
          if (sl_cnt >= sl_resp_lat) begin
            s_resp_valid = 1'b1;
            s_resp_rdata = sl_rdata;
          end
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    resp_q.delete(); sreq_q.delete(); acc_q.delete();
  endtask

  task automatic wait_resp(input int n, input string tag);
    int k = 0;
    while (resp_q.size() < n && k < 400) begin sync(); k++; end
    check(tag, resp_q.size() >= n, 1'b1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || sl_phase != 0) && k < 400) begin sync(); k++; end
    check("idle_reached", busy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    sync();
  endtask

  initial begin
    pend[0] = 0; pend[1] = 0;
    cyc = 0; sl_phase = 0; sl_cnt = 0; sl_resp_hs_cnt = 0;
    sl_req_lat = 1; sl_resp_lat = 1; sl_no_resp = 1'b0; sl_rdata = '0;
    exp_grant_chk = 2'b00; sel_fp = 1'b0;
    m_req_valid = 2'b00; m_req_addr = '0; m_req_write = 2'b00;
    m_req_wdata = '0; m_req_wstrb = '0; m_resp_ready = 2'b11;
    s_req_ready = 1'b0; s_resp_valid = 1'b0; s_resp_rdata = '0; s_resp_err = 1'b0;

    #1;
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_valids", {m_req_ready, m_resp_valid, s_req_valid}, 5'h00);
    check("rst_s_resp_ready", s_resp_ready, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    sync();

    // IFU-only read
    m_req_addr[31:0] = 32'h8000_0000; m_req_write[0] = 1'b0;
    sl_req_lat = 2; sl_resp_lat = 3; sl_rdata = 32'h0000_0413;
    exp_grant_chk = 2'b01;
    clear_logs();
    pend[0] = 1;
    wait_resp(1, "t1_done");
    check("t1_master", resp_q[0].m, 0);
    check("t1_rdata", resp_q[0].rdata, 32'h0000_0413);
    check("t1_err", resp_q[0].err, 1'b0);
    check("t1_s_addr", sreq_q[0].addr, 32'h8000_0000);
    check("t1_s_write", sreq_q[0].wr, 1'b0);
    wait_idle();
    exp_grant_chk = 2'b00;

    // Round-robin from reset: IFU wins the first tie, then alternation
    do_reset();
    sl_req_lat = 1; sl_resp_lat = 1;
    m_req_addr[63:32] = 32'h8000_0100;
    clear_logs();
    pend[0] = 2; pend[1] = 2;
    wait_resp(4, "t2_done");
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_order%0d", k), acc_q[k], exp_rr[k]);
      check($sformatf("t2_resp%0d", k), resp_q[k].m, exp_rr[k]);
    end
    wait_idle();

    // Fixed priority: LSU holds the port until it drops valid
    sel_fp = 1'b1;
    clear_logs();
    sync();
    pend[0] = 1; pend[1] = 4;
    wait_resp(5, "t3_done");
    for (int k = 0; k < 5; k++)
      check($sformatf("t3_order%0d", k), acc_q[k], exp_fp[k]);
    wait_idle();
    sel_fp = 1'b0;
    sync();

    // LSU store forwarded intact
    m_req_addr[63:32] = 32'h8000_1000; m_req_write[1] = 1'b1;
    m_req_wdata[63:32] = 32'hDEAD_BEEF; m_req_wstrb[7:4] = 4'b0011;
    sl_rdata = 32'h0000_0000; exp_grant_chk = 2'b10;
    clear_logs();
    pend[1] = 1;
    wait_resp(1, "t4_done");
    check("t4_s_addr", sreq_q[0].addr, 32'h8000_1000);
    check("t4_s_write", sreq_q[0].wr, 1'b1);
    check("t4_s_wdata", sreq_q[0].wdata, 32'hDEAD_BEEF);
    check("t4_s_wstrb", sreq_q[0].wstrb, 4'b0011);
    check("t4_master", resp_q[0].m, 1);
    check("t4_err", resp_q[0].err, 1'b0);
    wait_idle();
    m_req_write[1] = 1'b0;

    // Response in the last cycle before the timeout wins
    sl_resp_lat = 7; sl_rdata = 32'h7777_7777;
    clear_logs();
    pend[1] = 1;
    wait_resp(1, "t5_done");
    check("t5_err", resp_q[0].err, 1'b0);
    check("t5_rdata", resp_q[0].rdata, 32'h7777_7777);
    check("t5_latency", resp_q[0].cyc - sreq_q[0].cyc, 7);
    wait_idle();

    // Silent slave: error response 8 cycles into RESP, late reply absorbed
    begin
      int base;
      int k;
      sl_no_resp = 1'b1; sl_resp_lat = 2;
      m_req_addr[63:32] = 32'h8000_2000;
      clear_logs();
      pend[1] = 1;
      wait_resp(1, "t6_done");
      check("t6_master", resp_q[0].m, 1);
      check("t6_err", resp_q[0].err, 1'b1);
      check("t6_rdata", resp_q[0].rdata, 32'h0000_0000);
      check("t6_latency", resp_q[0].cyc - sreq_q[0].cyc, 8);
      sync();
      base = sl_resp_hs_cnt;
      sl_rdata = 32'h55AA_55AA;
      sl_no_resp = 1'b0;
      k = 0;
      while (sl_resp_hs_cnt == base && k < 50) begin sync(); k++; end
      check("t6_late_absorbed", sl_resp_hs_cnt - base, 1);
      check("t6_no_extra_resp", resp_q.size(), 1);
      exp_grant_chk = 2'b01;
      sl_rdata = 32'h0000_0513;
      pend[0] = 1;
      wait_resp(2, "t6_next_done");
      check("t6_next_master", resp_q[1].m, 0);
      check("t6_next_rdata", resp_q[1].rdata, 32'h0000_0513);
      check("t6_next_err", resp_q[1].err, 1'b0);
      wait_idle();
    end

    // Asynchronous reset while waiting in RESP
    begin
      int k = 0;
      sl_no_resp = 1'b1; sl_resp_lat = 1;
      m_req_addr[31:0] = 32'h8000_0040;
      clear_logs();
      pend[0] = 1;
      while (sreq_q.size() == 0 && k < 50) begin sync(); k++; end
      sync();
      sync();
      @(negedge clk);
      #2;
      check("t7_busy_before", busy, 1'b1);
      rst = 1'b0;
      #1;
      check("t7_grant", grant, 2'b00);
      check("t7_busy", busy, 1'b0);
      check("t7_valids", {m_req_ready, m_resp_valid, s_req_valid}, 5'h00);
      check("t7_s_resp_ready", s_resp_ready, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      sl_no_resp = 1'b0;
      rst = 1'b1;
      sync();
      clear_logs();
      sl_rdata = 32'h600D_600D;
      pend[0] = 1;
      wait_resp(1, "t7_done");
      check("t7_master", resp_q[0].m, 0);
      check("t7_rdata", resp_q[0].rdata, 32'h600D_600D);
      check("t7_err", resp_q[0].err, 1'b0);
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the core's single memory port between IFU (instruction fetch, master 0) and LSU (load/store, master 1) in the multicycle core with delayed memory.
- Sits between the fetch/decode/LSU control and the memory slave.
- Serialises transactions: only one is outstanding at a time, chosen by round-robin or fixed priority.
- Guards against a hung slave with a response-timeout counter that returns an error response.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; wstrb width is DATA_W/8
- TIMEOUT, 255, cycles to wait for a slave response before returning an error; 0 disables the timeout
- FIXED_PRIO, 0, 0 = round-robin between masters; 1 = LSU always wins over IFU

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- m_req_valid  in  2  per-master request valid; bit0 = IFU, bit1 = LSU
- m_req_ready  out  2  per-master request accepted
- m_req_addr  in  2*ADDR_W  per-master address
- m_req_write  in  2  per-master access type; 1 = store
- m_req_wdata  in  2*DATA_W  per-master write data
- m_req_wstrb  in  2*DATA_W/8  per-master byte strobes
- m_resp_valid  out  2  per-master response valid
- m_resp_ready  in  2  per-master response accept
- m_resp_rdata  out  DATA_W  response read data, shared by both masters
- m_resp_err  out  1  response error flag, shared by both masters
- s_req_valid  out  1  request to slave
- s_req_ready  in  1  slave accepts request
- s_req_addr  out  ADDR_W  forwarded address
- s_req_write  out  1  forwarded access type
- s_req_wdata  out  DATA_W  forwarded write data
- s_req_wstrb  out  DATA_W/8  forwarded byte strobes
- s_resp_valid  in  1  slave response valid
- s_resp_ready  out  1  arbiter accepts slave response
- s_resp_rdata  in  DATA_W  slave read data
- s_resp_err  in  1  slave error
- grant  out  2  one-hot owner of the current transaction; 0 when idle
- busy  out  1  state is not IDLE

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, grant = 0, last_grant = LSU (so IFU wins the first tie), timer = 0.
  - All valid and ready outputs are 0, except s_resp_ready, which is 1 (IDLE sink).
  - A transaction in flight when reset asserts is dropped; masters must re-issue it.
- Handshakes: a transfer occurs on valid & ready at a clk edge. Masters hold addr/write/wdata/wstrb stable from valid until ready.
- States: IDLE, REQ, RESP, TOUT.
- IDLE:
  - m_req_ready = 0.
  - If any m_req_valid bit is set, latch the winner into grant and go to REQ on the next edge. Grant latency is one cycle after the request is seen.
  - Winner selection:
    - FIXED_PRIO = 1: LSU wins.
    - FIXED_PRIO = 0: a single requester wins; if both request, the one not equal to last_grant wins.
  - s_resp_ready = 1: any stray or late slave response is accepted and discarded.
- REQ:
  - s_req_* is muxed from the granted master; s_req_valid = 1.
  - The granted master's m_req_ready = s_req_ready; the other master's m_req_ready = 0.
  - On s_req handshake: go to RESP and clear timer to 0.
  - No timeout applies in REQ.
  - A requester dropping valid here is a protocol violation; behaviour is unspecified.
- RESP:
  - Granted master's m_resp_valid = s_resp_valid.
  - s_resp_ready = granted master's m_resp_ready.
  - m_resp_rdata / m_resp_err are passed straight through from the slave.
  - On handshake: go to IDLE, set last_grant = grant, clear grant.
  - If s_resp_valid = 0, timer increments by 1 per cycle. Timer width is clog2(TIMEOUT+1) and saturates.
  - When timer == TIMEOUT and TIMEOUT != 0: go to TOUT.
  - If s_resp_valid arrives in the same cycle the timer reaches TIMEOUT, the response wins and no timeout is taken.
- TOUT:
  - Granted master sees m_resp_valid = 1, m_resp_err = 1, m_resp_rdata = 0; s_resp_ready = 0.
  - On m_resp_ready: go to IDLE and update last_grant.
  - A late slave response is absorbed afterwards by the IDLE sink.
- The non-granted master never sees m_req_ready or m_resp_valid asserted.
- Back-to-back: a request pending in the same cycle as a RESP handshake waits for IDLE. Minimum issue period is 3 cycles per transaction.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, REQ, RESP, TOUT), master index constants (M_IFU = 0, M_LSU = 1), one-hot grant constants.
- Sub-module arb_rr_pick: combinational winner select from req[1:0], last_grant and FIXED_PRIO, producing a one-hot output.
- The state register, timer and muxes stay in mem_arbiter.

Test Plan:
- IFU-only read at addr 0x80000000; slave ready after 2 cycles, response rdata 0x00000413 after 3 cycles -> IFU gets m_resp_valid with rdata 0x00000413, err 0; grant = 01 throughout; LSU outputs stay 0.
- IFU and LSU request in the same cycle after reset, FIXED_PRIO = 0 -> IFU served first, then LSU. Repeat both requesting -> order alternates IFU, LSU, IFU.
- FIXED_PRIO = 1, both requesting continuously for 4 transactions -> all 4 granted to LSU; IFU is served only once LSU drops valid.
- LSU store to addr 0x80001000, wdata 0xDEADBEEF, wstrb 0b0011 -> the slave sees exactly those values and s_req_write = 1; the slave response is returned to the LSU.
- TIMEOUT = 8, slave never responds -> LSU gets m_resp_err = 1, rdata 0 exactly 8 cycles after entering RESP. A late s_resp_valid in IDLE is acknowledged and dropped, and the next IFU transaction completes normally.
- Reset asserted while in RESP -> grant, busy and all valids clear immediately (asynchronously). After release, a fresh IFU request completes normally.
